// File: rtl/gpr_master.sv
// rtl/gpr_master.sv - register-file master: READ3 sum, WRITE, MOVE with optional r15 protect (GPR_MASTER_FLAG_PROTECT_EN)
module gpr_master #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [REG_W-1:0]     req_dst,
    input  logic [3*REG_W-1:0]   req_src,
    input  logic [DATA_W-1:0]    req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 GPR_rd,
    output logic                 GPR_wr,
    output logic [ADDR_W-1:0]    gpr_addr_wr,
    output logic [ADDR_W-1:0]    gpr_addr_rd,
    output logic [DATA_W-1:0]    gpr_wdata,
    input  logic [DATA_W-1:0]    gpr_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_READ3 = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;

    localparam int RD_SHIFT = ADDR_W - 3*REG_W;
    localparam int WR_SHIFT = ADDR_W - REG_W;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [REG_W-1:0]   dst_q;
    logic [3*REG_W-1:0] src_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  sum_q;
    logic [DATA_W-1:0]  wr_value;
    logic               prot_req;
    logic               prot_q;

    // Writes to the top register are refused when protection is built in.
`ifdef GPR_MASTER_FLAG_PROTECT_EN
    assign prot_req = &req_dst;
    assign prot_q   = &dst_q;
`else
    assign prot_req = 1'b0;
    assign prot_q   = 1'b0;
`endif

    assign wr_value = (op_q == OP_WRITE) ? data_q : sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            data_q   <= '0;
            sum_q    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        dst_q    <= req_dst;
                        src_q    <= req_src;
                        data_q   <= req_data;
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                        case (req_op)
                            OP_READ3, OP_MOVE: state <= S_READ;
                            OP_WRITE: begin
                                if (prot_req) begin
                                    state   <= S_RESP;
                                    rsp_err <= 1'b1;
                                end else begin
                                    state <= S_WRITE;
                                end
                            end
                            default: begin
                                state   <= S_RESP;
                                rsp_err <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    sum_q <= gpr_rdata;
                    if (op_q == OP_MOVE) begin
                        if (prot_q) begin
                            state   <= S_RESP;
                            rsp_err <= 1'b1;
                        end else begin
                            state <= S_WRITE;
                        end
                    end else begin
                        rsp_data <= gpr_rdata;
                        state    <= S_RESP;
                    end
                end
                S_WRITE: begin
                    rsp_data <= wr_value;
                    state    <= S_RESP;
                end
                default: begin
                    if (rsp_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and buses decode straight from state so they are exactly one cycle wide.
    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign GPR_rd      = (state == S_READ);
    assign GPR_wr      = (state == S_WRITE);
    assign gpr_addr_rd = GPR_rd ? (ADDR_W'(src_q) << RD_SHIFT) : '0;
    assign gpr_addr_wr = GPR_wr ? (ADDR_W'(dst_q) << WR_SHIFT) : '0;
    assign gpr_wdata   = GPR_wr ? wr_value : '0;

endmodule

// File: doc/gpr_master.md
GPR_MASTER -- requirements
Module: gpr_master

Interface
REQ-001 Parameter DATA_W, default 14, register data width.
REQ-002 Parameter ADDR_W, default 12, register-file address bus width.
REQ-003 Parameter REG_W, default 4, register index field width (16 registers).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  master idle and accepting.
REQ-008 req_op  input  2  00 READ3, 01 WRITE, 10 MOVE, 11 reserved.
REQ-009 req_dst  input  REG_W  destination register index.
REQ-010 req_src  input  3*REG_W  source indices: A in [3*REG_W-1:2*REG_W], B in the middle field, C in [REG_W-1:0].
REQ-011 req_data  input  DATA_W  write data for WRITE.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_data  output  DATA_W  read sum or written value.
REQ-015 rsp_err  output  1  request rejected.
REQ-016 GPR_rd, GPR_wr  output  1 each  register-file read and write strobes.
REQ-017 gpr_addr_wr, gpr_addr_rd  output  ADDR_W each  register-file write and read addresses.
REQ-018 gpr_wdata  output  DATA_W  register-file write data.
REQ-019 gpr_rdata  input  DATA_W  register-file read result (sum of three addressed registers).

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Handshake: a request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; all request fields SHALL be registered at acceptance.
REQ-022 Transitions: READ3 IDLE->READ->RESP; WRITE IDLE->WRITE->RESP; MOVE IDLE->READ->WRITE->RESP; reserved op IDLE->RESP with rsp_err=1 and rsp_data=0.
REQ-023 In READ, GPR_rd SHALL be 1 for exactly one cycle, gpr_addr_rd SHALL equal {A,B,C} left-aligned with zeros in the low ADDR_W-3*REG_W bits, and gpr_rdata SHALL be captured at the end of that cycle.
REQ-024 In WRITE, GPR_wr SHALL be 1 for exactly one cycle, gpr_addr_wr SHALL equal {dst, zeros}, and gpr_wdata SHALL equal req_data (WRITE) or the captured sum (MOVE).
REQ-025 GPR_rd and GPR_wr SHALL never be 1 in the same cycle; outside their strobe cycles addresses and gpr_wdata SHALL be 0.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be stable until rsp_ready=1; the FSM SHALL then return to IDLE on that edge.
REQ-027 rsp_data SHALL be the captured sum for READ3 and the written value for WRITE and MOVE.
REQ-028 Latency from acceptance to rsp_valid SHALL be 2 cycles for READ3 and WRITE, and 3 cycles for MOVE.
REQ-029 Back-to-back: a new request SHALL be accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-030 With rst=1 at a rising edge, state SHALL become IDLE, and rsp_valid, rsp_err, GPR_rd, GPR_wr, addresses, gpr_wdata and rsp_data SHALL become 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no further strobe, and req_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-032 With GPR_MASTER_FLAG_PROTECT_EN defined, WRITE or MOVE with dst=15 SHALL skip WRITE (no GPR_wr) and respond with rsp_err=1; without the macro such writes SHALL proceed normally.

Verification
REQ-033 Reset, then WRITE dst=2, data=0x1234 -> one-cycle GPR_wr with gpr_addr_wr=0x200 and gpr_wdata=0x1234, rsp_data=0x1234 two cycles after acceptance.
REQ-034 READ3 src A=1, B=2, C=3 with gpr_rdata=0x0042 -> gpr_addr_rd=0x123, rsp_data=0x0042, rsp_err=0.
REQ-035 MOVE dst=5, src=(0,1,2) with gpr_rdata=0x0007 -> GPR_rd cycle, then GPR_wr with gpr_addr_wr=0x500 and gpr_wdata=0x0007, rsp_valid on cycle 3.
REQ-036 rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout, no strobes.
REQ-037 Op 11 -> no strobes, rsp_err=1, rsp_data=0; rst asserted during MOVE READ -> no GPR_wr, all outputs 0.
REQ-038 WRITE dst=15 -> rsp_err=1 and no GPR_wr with GPR_MASTER_FLAG_PROTECT_EN defined; normal write without it.
